// File: rtl/wt_cache_ctrl.sv
// Controller for a 128-word direct-mapped write-through cache (32 lines x 4 words, no write-allocate).
// Optional hit/miss statistics counters are enabled with the WT_CACHE_STATS_EN macro.
module wt_cache_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LINES  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              stall,
    output logic              mem_read,
    output logic              cach_write,
    output logic              miss_read,
    output logic [1:0]        counter,
    output logic [6:0]        cache_addr,
    output logic              mm_rd,
    output logic              mm_wr,
    output logic [ADDR_W-1:0] mm_addr,
    input  logic              mm_ready
`ifdef WT_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int unsigned TAG_W = ADDR_W - 7;
    localparam int unsigned IDX_W = 5;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_counter;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag [LINES];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_stall;
    logic              w_mem_read;
    logic              w_cach_write;
    logic              w_miss_read;
    logic              w_mm_rd;
    logic              w_mm_wr;
    logic [ADDR_W-1:0] w_mm_addr;
    logic              w_latch;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_fill_done;

    assign w_idx = cpu_addr[6:2];
    assign w_tag = cpu_addr[ADDR_W-1:7];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Next-state and strobe decode; index/tag are latched on IDLE exit.
    always_comb begin
        w_next       = r_state;
        w_stall      = 1'b0;
        w_mem_read   = 1'b0;
        w_cach_write = 1'b0;
        w_miss_read  = 1'b0;
        w_mm_rd      = 1'b0;
        w_mm_wr      = 1'b0;
        w_mm_addr    = '0;
        w_latch      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_wr) begin
                    w_cach_write = w_hit;
                    w_stall      = 1'b1;
                    w_latch      = 1'b1;
                    w_next       = S_WRITE;
                end else if (cpu_rd) begin
                    if (w_hit) begin
                        w_mem_read = 1'b1;
                    end else begin
                        w_stall   = 1'b1;
                        w_latch   = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                w_stall     = 1'b1;
                w_mm_rd     = 1'b1;
                w_mm_addr   = {r_addr[ADDR_W-1:2], r_counter};
                w_miss_read = mm_ready;
                if (mm_ready) begin
                    w_cnt_inc = 1'b1;
                    if (r_counter == 2'd3) begin
                        w_fill_done = 1'b1;
                        w_next      = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                w_stall   = ~mm_ready;
                w_mm_wr   = 1'b1;
                w_mm_addr = r_addr;
                if (mm_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_counter <= 2'd0;
            r_valid   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr <= cpu_addr;
            end
            if (w_cnt_clr) begin
                r_counter <= 2'd0;
            end else if (w_cnt_inc) begin
                r_counter <= r_counter + 2'd1;
            end
            if (w_fill_done) begin
                r_valid[r_addr[6:2]] <= 1'b1;
            end
        end
    end

    // Tag contents are meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag[r_addr[6:2]] <= r_addr[ADDR_W-1:7];
        end
    end

    assign stall      = w_stall      & ~rst;
    assign mem_read   = w_mem_read   & ~rst;
    assign cach_write = w_cach_write & ~rst;
    assign miss_read  = w_miss_read  & ~rst;
    assign mm_rd      = w_mm_rd      & ~rst;
    assign mm_wr      = w_mm_wr      & ~rst;
    assign mm_addr    = rst ? '0 : w_mm_addr;
    assign counter    = r_counter;
    assign cache_addr = cpu_addr[6:0];

`ifdef WT_CACHE_STATS_EN
    logic        w_req_idle;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    assign w_req_idle = (r_state == S_IDLE) && (cpu_rd || cpu_wr);

    // Saturating event counters; a store counts as hit or miss in its IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
        end else if (w_req_idle) begin
            if (w_hit && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (!w_hit && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/wt_cache_ctrl.md
Name: wt_cache_ctrl

Overview:
- Controller for the 128-word write-through data cache: direct-mapped, 32 lines x 4 words, no write-allocate.
- Holds the tag and valid arrays and decides hit or miss.
- Drives the cache array strobes: mem_read, cach_write, miss_read, counter, addr.
- Sequences 4-beat line refills from main memory and write-through stores, stalling the CPU meanwhile.

Parameters:
- ADDR_W, 10, CPU word-address width; tag = ADDR_W-7 bits (min 8).
- LINES, 32, cache lines; index = addr[6:2], offset = addr[1:0]; fixed to match the 128-word array.

Ports:
- clk  in  1  clock; all state changes on posedge (cache array writes on negedge).
- rst  in  1  asynchronous, active-high reset.
- cpu_rd  in  1  read request; held with cpu_addr until stall=0.
- cpu_wr  in  1  write request; held with cpu_addr and data until stall=0.
- cpu_addr  in  ADDR_W  word address.
- stall  out  1  CPU must hold its request.
- mem_read  out  1  cache array read enable.
- cach_write  out  1  cache array write of the CPU word (hit store).
- miss_read  out  1  cache array refill-beat write.
- counter  out  2  refill beat index.
- cache_addr  out  7  cache array address = cpu_addr[6:0].
- mm_rd  out  1  main-memory read request.
- mm_wr  out  1  main-memory write request.
- mm_addr  out  ADDR_W  main-memory word address.
- mm_ready  in  1  one-cycle beat/ack from main memory.

Behaviour:
- States: IDLE, REFILL, WRITE.
- Reset: state=IDLE, all valid bits=0, counter=0. Every output is 0 during reset, except cache_addr, which follows cpu_addr.
- hit = valid[index] & (tag_arr[index] == cpu_addr[ADDR_W-1:7]).
- IDLE, cpu_wr=1: cpu_wr has priority if cpu_rd and cpu_wr are both high.
  - cach_write = hit in this cycle.
  - stall=1; next state WRITE.
- IDLE, cpu_rd=1 and hit: mem_read=1, stall=0. Zero-wait read.
- IDLE, cpu_rd=1 and miss: stall=1, counter<=0; next state REFILL.
- IDLE, no request: stall=0, all strobes 0.
- REFILL:
  - stall=1, mm_rd=1, mm_addr={cpu_addr[ADDR_W-1:2], counter}.
  - miss_read = mm_ready.
  - On each mm_ready, counter increments at posedge, after the negedge array write of that beat.
  - On mm_ready with counter==3: valid[index]<=1, tag_arr[index]<=tag, counter wraps to 0, state<=IDLE.
  - The next IDLE cycle hits and returns data. Read-miss latency = 1 + 4 beats + 1 cycle minimum.
- WRITE:
  - stall=1, mm_wr=1, mm_addr=cpu_addr.
  - On mm_ready: state<=IDLE and stall=0 in that same cycle. The CPU may drop the request at the following posedge.
  - Miss stores do not touch tags or the array.
- mm_rd and mm_wr are never high together. cach_write and miss_read are never high together.
- mm_ready outside REFILL/WRITE is ignored.
- Reset mid-REFILL: the partially loaded line stays invalid. After reset, re-access to that line misses.
- Request dropped mid-operation is illegal. The controller completes the current operation using the latched index/tag, which are latched at IDLE exit.

Optional Feature:
- WT_CACHE_STATS_EN:
  - Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0], reset to 0.
  - hit_cnt increments once per accepted read hit in IDLE, and once per store that hits.
  - miss_cnt increments once per IDLE→REFILL and per store that misses.
  - Both counters saturate at 16'hFFFF.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then cpu_rd addr 10'h004 with mm_ready every 2nd cycle -> 4 beats, miss_read/counter 0,1,2,3, mm_addr 004..007; then mem_read=1, stall=0; valid[1] set.
- Read addr 10'h006 right after -> hit in 1 cycle, no mm_rd.
- cpu_wr addr 10'h005 (hit), mm_ready after 3 cycles -> cach_write=1 in first cycle only, mm_wr held 3 cycles, stall drops on ack.
- cpu_wr addr 10'h285 (same index, different tag) -> cach_write=0, mm_wr only; subsequent read of 10'h285 misses and refills 284..287.
- Assert rst during beat 2 of a refill -> outputs 0 immediately; re-read of the same address performs a full 4-beat refill.
- cpu_rd and cpu_wr both high, addr 10'h010 -> WRITE path taken, no refill (with WT_CACHE_STATS_EN: miss_cnt=1, hit_cnt=0).
